// File: rtl/bp_be_pkg.sv
// Shared types for the backend prefetch dispatch arbiter.
//   bp_be_pref_arb_state_e : arbiter FSM state encoding
//   line_tag_width()       : width of the cache-line tag used for prefetch dedup
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_wait   = 2'd1,
    e_bubble = 2'd2
  } bp_be_pref_arb_state_e;

  // Line tag is the vaddr with the in-line byte offset stripped.
  function automatic int unsigned line_tag_width(input int unsigned vaddr_width,
                                                 input int unsigned block_offset);
    return vaddr_width - block_offset;
  endfunction

endpackage

// File: rtl/bp_be_prefetch_dispatch_arbiter_fifo.sv
// Small registered 1R1W FIFO with a synchronous clear that empties the buffer
// without touching the reset network.
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   clear_i           drop all entries (pointer reset), priority over v_i/yumi_i
//   v_i, data_i       enqueue (caller guarantees ~full_o)
//   yumi_i            dequeue head (caller guarantees ~empty_o)
//   full_o, empty_o   registered status flags
//   data_o            head entry
module bp_be_prefetch_dispatch_arbiter_fifo #(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 39
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW-1:0]    wptr_inc, rptr_inc;
  logic               full_q, full_d, empty_q, empty_d;

  assign wptr_inc = wptr_q + PtrW'(1);
  assign rptr_inc = rptr_q + PtrW'(1);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      full_d  = 1'b0;
      empty_d = 1'b1;
    end else if (v_i && !yumi_i) begin
      wptr_d  = wptr_inc;
      empty_d = 1'b0;
      full_d  = (wptr_inc == rptr_q);
    end else if (!v_i && yumi_i) begin
      rptr_d  = rptr_inc;
      full_d  = 1'b0;
      empty_d = (rptr_inc == wptr_q);
    end else if (v_i && yumi_i) begin
      // Occupancy unchanged; flags stay as they are.
      wptr_d = wptr_inc;
      rptr_d = rptr_inc;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clk_i) begin
    if (v_i && !clear_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/bp_be_prefetch_dispatch_arbiter.sv
// Shares the backend dispatch slot between demand dispatch and buffered prefetches.
// Prefetches are queued, deduplicated against the last injected cache line and
// injected only in cycles without a demand dispatch. A starvation FSM requests a
// scheduler bubble when the head has been blocked for too long.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   enable_i                  prefetch injection enable
//   flush_i                   drop all buffered prefetches and the dedup line
//   pref_v_i, pref_vaddr_i    prefetch request; pref_ready_and_o accepts it
//   dispatch_v_i              demand dispatch occupies the slot this cycle
//   inj_v_o, inj_vaddr_o      prefetch injected into the slot (combinational)
//   bubble_req_o              ask the scheduler to hold demand issue (registered)
//   drop_cnt_o                saturating count of deduplicated prefetches
module bp_be_prefetch_dispatch_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned fifo_els_p     = 4,
  parameter int unsigned block_offset_p = 6,
  parameter int unsigned starve_limit_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     pref_v_i,
  input  logic [vaddr_width_p-1:0] pref_vaddr_i,
  output logic                     pref_ready_and_o,
  input  logic                     dispatch_v_i,
  output logic                     inj_v_o,
  output logic [vaddr_width_p-1:0] inj_vaddr_o,
  output logic                     bubble_req_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned TagW    = line_tag_width(vaddr_width_p, block_offset_p);
  localparam int unsigned StarveW = $clog2(starve_limit_p + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(starve_limit_p - 1);

  logic                     fifo_full, fifo_empty;
  logic [vaddr_width_p-1:0] head_vaddr;
  logic [TagW-1:0]          head_tag;
  logic                     enq, deq, dup, grant, blocked;

  logic [TagW-1:0]          last_line_q;
  logic                     last_line_v_q;
  logic [15:0]              drop_cnt_q;
  logic [StarveW-1:0]       starve_q, starve_d;
  bp_be_pref_arb_state_e    state_q, state_d;

  bp_be_prefetch_dispatch_arbiter_fifo #(
    .els_p   (fifo_els_p),
    .width_p (vaddr_width_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .v_i     (enq),
    .data_i  (pref_vaddr_i),
    .yumi_i  (deq),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head_vaddr)
  );

  assign head_tag = head_vaddr[vaddr_width_p-1:block_offset_p];

  // Ready held low during reset so nothing is accepted into a resetting buffer.
  assign pref_ready_and_o = ~fifo_full & ~flush_i & ~reset_i;
  assign enq              = pref_v_i & pref_ready_and_o;

  // Dup drops bypass enable and demand traffic: they never use the slot.
  assign dup     = ~flush_i & ~fifo_empty & last_line_v_q & (head_tag == last_line_q);
  assign grant   = ~flush_i & ~fifo_empty & ~dup & enable_i & ~dispatch_v_i;
  assign blocked = ~flush_i & ~fifo_empty & ~dup & enable_i & dispatch_v_i;
  assign deq     = dup | grant;

  assign inj_v_o     = grant;
  assign inj_vaddr_o = grant ? head_vaddr : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_line_q   <= '0;
      last_line_v_q <= 1'b0;
    end else if (flush_i) begin
      last_line_v_q <= 1'b0;
    end else if (grant) begin
      last_line_q   <= head_tag;
      last_line_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
    end else if (dup && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

  // The first blocked cycle is seen in e_idle; e_wait then counts starve_limit_p
  // further blocked cycles, so the bubble appears starve_limit_p+1 cycles later.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (flush_i) begin
      state_d  = e_idle;
      starve_d = '0;
    end else begin
      unique case (state_q)
        e_idle: begin
          if (blocked) begin
            state_d  = e_wait;
            starve_d = '0;
          end
        end
        e_wait: begin
          if (grant || fifo_empty || !enable_i) begin
            state_d  = e_idle;
            starve_d = '0;
          end else if (blocked) begin
            if (starve_q == StarveMax) begin
              state_d = e_bubble;
            end else begin
              starve_d = starve_q + StarveW'(1);
            end
          end
        end
        e_bubble: begin
          if (grant || fifo_empty || !enable_i) begin
            state_d  = e_idle;
            starve_d = '0;
          end
        end
        default: begin
          state_d  = e_idle;
          starve_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign bubble_req_o = (state_q == e_bubble);

endmodule

// File: doc/bp_be_prefetch_dispatch_arbiter.md
# bp_be_prefetch_dispatch_arbiter

Shares the single backend dispatch slot between demand traffic from the scheduler and software-invisible prefetch requests from the loop/stride prefetch generator. Prefetch requests are buffered, deduplicated by cache line, and injected only in cycles with no demand dispatch. A starvation counter can request a one-cycle issue bubble so prefetches are not starved indefinitely. The block sits between the prefetch generator and the scheduler's final dispatch mux.

## Interface
- vaddr_width_p, 39, virtual address width
- fifo_els_p, 4, prefetch buffer depth (power of 2, ≥2)
- block_offset_p, 6, log2 of cache line bytes; dedup compares vaddr[vaddr_width_p-1:block_offset_p]
- starve_limit_p, 16, consecutive blocked cycles before a bubble is requested (≥1)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  prefetch injection enable (CSR-driven)
- flush_i  in  1  clear all buffered prefetches (tied to issue clear / pipeline flush)
- pref_v_i  in  1  prefetch request valid
- pref_vaddr_i  in  vaddr_width_p  prefetch effective address
- pref_ready_and_o  out  1  request accepted when pref_v_i & pref_ready_and_o
- dispatch_v_i  in  1  demand dispatch packet valid this cycle
- inj_v_o  out  1  inject prefetch into dispatch slot this cycle
- inj_vaddr_o  out  vaddr_width_p  address of injected prefetch
- bubble_req_o  out  1  request scheduler to suppress demand issue for one cycle
- drop_cnt_o  out  16  saturating count of deduplicated (dropped) prefetches

## Operation
- Buffer: FIFO of fifo_els_p vaddrs. Enqueue on pref_v_i & pref_ready_and_o. pref_ready_and_o = ~full & ~flush_i.
- Head handling, evaluated each cycle when FIFO non-empty and ~flush_i:
  - Dup: head line == last_line_r and last_line_v_r → dequeue, no inject, drop_cnt_o += 1 (saturate at 16'hFFFF). Dup drop ignores enable_i and dispatch_v_i.
  - Grant: not dup, enable_i, ~dispatch_v_i → inj_v_o=1, inj_vaddr_o=head, dequeue, last_line_r ← head line, last_line_v_r ← 1.
  - Otherwise head held.
- FSM states e_idle, e_wait, e_bubble:
  - e_idle: FIFO empty or enable_i low. → e_wait when non-empty & enable_i.
  - e_wait: counter starve_r increments each cycle head is blocked by dispatch_v_i. Grant → e_idle (counter 0). starve_r == starve_limit_p-1 while blocked → e_bubble.
  - e_bubble: bubble_req_o=1 (Moore, registered state). Leaves on grant → e_idle, or on FIFO empty/enable_i low → e_idle. Stays asserted while dispatch_v_i remains high (scheduler priority items may override).
- flush_i: FIFO emptied, last_line_v_r ← 0, FSM → e_idle, starve_r ← 0, inj_v_o forced 0 in that cycle; drop_cnt_o unaffected.
- Simultaneous enqueue and dequeue when full: not allowed (ready low when full, registered full flag).
- enable_i low: no injects, no bubble; buffered entries retained; enqueue continues.

## Timing
- Reset values: pref_ready_and_o 1 (after reset deasserts; 0 during reset), inj_v_o 0, inj_vaddr_o 0, bubble_req_o 0, drop_cnt_o 0, FIFO empty, last_line_v_r 0, state e_idle.
- Enqueue-to-inject latency minimum 1 cycle (FIFO registered, no bypass).
- inj_v_o, inj_vaddr_o combinational from FIFO head, last_line_r, enable_i, dispatch_v_i, flush_i; single-cycle valid, no ready (scheduler must accept when dispatch_v_i low).
- bubble_req_o asserted first in cycle starve_limit_p+1 after head first blocked (Moore).
- Dup drop consumes one cycle per entry.

## Structure
- Arbiter FSM enum (e_idle/e_wait/e_bubble) and line-tag width macro go in bp_be_pkg.
- FIFO: bsg_fifo_1r1w_small (els_p=fifo_els_p, width_p=vaddr_width_p); flush via its reset input OR'd with reset_i is not allowed — implement flush as read-all pointer reset inside a local wrapper or an explicit clear port.
- Everything else (counters, FSM, dedup register) local to this module.

## Test plan
- Enqueue 0x1000, dispatch_v_i=0, enable_i=1 → inj_v_o=1, inj_vaddr_o=0x1000 one cycle later; FIFO empty after.
- Enqueue 0x1000 then 0x1020 (same 64B line) → first injected, second dropped, drop_cnt_o=1, one inject only.
- Fill with 4 requests, dispatch_v_i=1 constant → pref_ready_and_o=0, bubble_req_o rises 17 cycles after first block; drop dispatch_v_i one cycle → inject, bubble_req_o falls next cycle.
- flush_i with 3 buffered entries, dispatch_v_i=0 → no inject in flush cycle, FIFO empty, next 0x1000 re-enqueued is injected (not dedup-dropped).
- enable_i=0 with 2 buffered → no injects, no bubble for 100 cycles; enable_i=1 → both injected in consecutive idle cycles.
- Assert reset_i asynchronously mid-bubble → bubble_req_o, inj_v_o drop immediately; drop_cnt_o=0.
